batch_norm_pipe: RTL and testbench
==================================

// Module: batch_norm_pipe
// PURPOSE
//   Multi-channel, pipelined batch-normalisation stage for the CNN datapath.
//   Computes out = sat(round(((din - mu[ch]) * delta[ch] + beta[ch]) >>> FRAC_SH)).
//   Per-channel coefficients live in a writable register bank; data moves on a valid/ready stream.
//   Sits between a conv/accumulate stage and the pooling/activation stage.
// PARAMETERS
//   IN_W    21  signed input sample width
//   COEF_W  18  signed width of mu, delta and beta
//   OUT_W    9  signed output width, saturated
//   FRAC_SH 13  fractional bits of delta; delta = 1<<FRAC_SH is unity gain
//   NCH      8  number of channels in the coefficient bank
//   CH_W     3  channel index width, equal to $clog2(NCH)
//   CNT_W   16  width of the saturation counter
// PORTS
//   clk        in   1       clock
//   rst        in   1       synchronous reset, active-high
//   in_valid   in   1       input sample valid
//   in_ready   out  1       block accepts the input sample this cycle
//   in_data    in   IN_W    signed input sample
//   in_ch      in   CH_W    channel of the input sample
//   out_valid  out  1       output valid
//   out_ready  in   1       downstream accepts the output
//   out_data   out  OUT_W   normalised, saturated result
//   out_ch     out  CH_W    channel tag of out_data
//   cfg_we     in   1       coefficient write strobe
//   cfg_ch     in   CH_W    channel to write
//   cfg_sel    in   2       00 = mu, 01 = delta, 10 = beta, 11 = ignored
//   cfg_data   in   COEF_W  coefficient value
//   sat_cnt    out  CNT_W   count of saturated outputs; sticks at all-ones
//   err_ch     out  1       sticky flag; set when in_ch >= NCH is accepted
// BEHAVIOUR
//   Clock and reset
//     One clock, clk. Reset rst is synchronous and active-high.
//     On rst: out_valid=0, out_data=0, out_ch=0, sat_cnt=0, err_ch=0, all stage valids=0.
//     Also on rst, for every channel: mu=0, delta=1<<FRAC_SH, beta=0.
//     rst applied mid-operation drops in-flight samples without emitting them.
//   Pipeline (3 stages)
//     S1: diff = din - mu; captures delta, beta and ch.
//     S2: prod = diff * delta.
//     S3: acc = prod + beta + (1<<(FRAC_SH-1)), then >>> FRAC_SH, then saturate.
//     Latency: accept at cycle t gives out_valid at t+3 when there is no stall.
//   Handshake
//     adv = !out_valid | out_ready. in_ready = adv.
//     The whole pipeline shifts only when adv=1. A transfer happens on valid & ready.
//     While out_valid=1 and out_ready=0: out_data and out_ch hold stable.
//     Throughput is 1 sample per clock. No sample is lost or duplicated.
//   Widths and arithmetic
//     diff is IN_W+1 bits; prod and acc are IN_W+COEF_W+2 bits, all signed.
//     The internal datapath never wraps.
//     beta is in the product scale, i.e. Q(FRAC_SH).
//     Saturation clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//     Each clamped output increments sat_cnt once, counted at the output transfer.
//   Coefficients
//     A cfg_we write takes effect for samples accepted in a later cycle.
//     Samples already in flight use the coefficients latched at S1.
//     A write in the same cycle as an accept to the same channel: the accepted sample uses the OLD value.
//     Writes with cfg_ch >= NCH or cfg_sel = 11 are ignored.
//   Invalid input channel
//     A sample with in_ch >= NCH flows through with out_data=0, sets err_ch, and is not counted in sat_cnt.
// CONFIGURATION
//   BN_RELU_EN defined:
//     fused ReLU after saturation; a negative result emits 0.
//     A negative clamp is not counted in sat_cnt.
//   BN_RELU_EN undefined:
//     signed output as above; no ReLU logic is instantiated.
// STRUCTURE
//   Shared include/package cnn_bn_pkg holds:
//     the defaults IN_W/COEF_W/OUT_W/FRAC_SH;
//     CFG_MU=2'b00, CFG_DELTA=2'b01, CFG_BETA=2'b10;
//     the saturation bound constants.
//   Sub-module bn_coef_bank: NCH x {mu, delta, beta} registers.
//     Synchronous write, combinational read, reset to defaults.
//   Pipeline and handshake logic stay in batch_norm_pipe.
// TESTING (FRAC_SH=13, OUT_W=9, unity delta=8192)
//   1 Unity gain: ch0 defaults, din=100 -> out_data=100 at accept+3, sat_cnt=0.
//   2 Saturation: din=1000 -> out_data=255; din=-1000 -> out_data=-256
//     (0 with BN_RELU_EN); sat_cnt=2 (1 with BN_RELU_EN).
//   3 Rounding and offset: ch2 delta=4096, beta=40960.
//     din=3 -> 7 (1.5+5 rounds up); din=-3 -> 4 (-1.5+5=3.5 rounds up).
//     ch2 mu=10, beta=0, din=13 -> 2.
//   4 Backpressure: in_valid=1 streaming 0..15, out_ready low for 5 cycles mid-stream.
//     Output is exactly 0..15 in order; data held stable while stalled.
//     in_ready=0 whenever out_valid & !out_ready.
//   5 Config race: write ch1 mu=50 in the same cycle din=60 on ch1 is accepted -> out 60.
//     Next sample din=60 -> out 10. cfg_ch=9 write ignored.
//   6 Reset mid-flight: 3 samples in flight, rst for 1 cycle.
//     out_valid=0 the next cycle; nothing emitted.
//     Coefficients back to defaults; sat_cnt=0; err_ch=0.

Source files
------------

// File: rtl/cnn_bn_pkg.sv
// Shared defaults, coefficient-select codes and saturation bounds for the
// batch-normalisation stage.
package cnn_bn_pkg;

    localparam int DEF_IN_W    = 21;
    localparam int DEF_COEF_W  = 18;
    localparam int DEF_OUT_W   = 9;
    localparam int DEF_FRAC_SH = 13;

    typedef enum logic [1:0] {
        CFG_MU    = 2'b00,
        CFG_DELTA = 2'b01,
        CFG_BETA  = 2'b10,
        CFG_NONE  = 2'b11
    } cfg_sel_e;

    localparam int SAT_HI = (1 << (DEF_OUT_W - 1)) - 1;
    localparam int SAT_LO = -(1 << (DEF_OUT_W - 1));

    function automatic longint sat_hi(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint sat_lo(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/bn_coef_bank.sv
// Per-channel {mu, delta, beta} register bank: synchronous write, combinational
// read, reset to identity (mu=0, delta=unity, beta=0).
module bn_coef_bank
    import cnn_bn_pkg::*;
#(
    parameter int NCH     = 8,
    parameter int CH_W    = 3,
    parameter int COEF_W  = DEF_COEF_W,
    parameter int FRAC_SH = DEF_FRAC_SH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [CH_W-1:0]          wr_ch,
    input  logic [1:0]               sel,
    input  logic signed [COEF_W-1:0] wr_data,
    input  logic [CH_W-1:0]          rd_ch,
    output logic signed [COEF_W-1:0] rd_mu,
    output logic signed [COEF_W-1:0] rd_delta,
    output logic signed [COEF_W-1:0] rd_beta
);

    localparam logic signed [COEF_W-1:0] UNITY = COEF_W'(longint'(1) << FRAC_SH);
    localparam logic [CH_W:0]            NCH_L = (CH_W + 1)'(NCH);

    logic signed [COEF_W-1:0] mu    [NCH];
    logic signed [COEF_W-1:0] delta [NCH];
    logic signed [COEF_W-1:0] beta  [NCH];
    logic wr_ok;
    logic rd_ok;

    // One extra index bit keeps the range check meaningful when NCH == 2**CH_W.
    assign wr_ok = we && ({1'b0, wr_ch} < NCH_L);
    assign rd_ok = {1'b0, rd_ch} < NCH_L;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                mu[i]    <= '0;
                delta[i] <= UNITY;
                beta[i]  <= '0;
            end
        end else if (wr_ok) begin
            case (cfg_sel_e'(sel))
                CFG_MU:    mu[wr_ch]    <= wr_data;
                CFG_DELTA: delta[wr_ch] <= wr_data;
                CFG_BETA:  beta[wr_ch]  <= wr_data;
                default:   ;
            endcase
        end
    end

    always_comb begin
        rd_mu    = '0;
        rd_delta = UNITY;
        rd_beta  = '0;
        if (rd_ok) begin
            rd_mu    = mu[rd_ch];
            rd_delta = delta[rd_ch];
            rd_beta  = beta[rd_ch];
        end
    end

endmodule

// File: rtl/batch_norm_pipe.sv
// Three-stage batch-normalisation pipeline with valid/ready stream and
// saturation counter. Define BN_RELU_EN to fuse a ReLU after saturation.
module batch_norm_pipe
    import cnn_bn_pkg::*;
#(
    parameter int IN_W    = DEF_IN_W,
    parameter int COEF_W  = DEF_COEF_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int FRAC_SH = DEF_FRAC_SH,
    parameter int NCH     = 8,
    parameter int CH_W    = 3,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [IN_W-1:0]   in_data,
    input  logic [CH_W-1:0]          in_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic [CH_W-1:0]          out_ch,
    input  logic                     cfg_we,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [1:0]               cfg_sel,
    input  logic signed [COEF_W-1:0] cfg_data,
    output logic [CNT_W-1:0]         sat_cnt,
    output logic                     err_ch
);

    localparam int DW = IN_W + 1;
    localparam int PW = IN_W + COEF_W + 2;
    localparam logic [CH_W:0]        NCH_L = (CH_W + 1)'(NCH);
    localparam logic signed [PW-1:0] RND   = PW'(longint'(1) << (FRAC_SH - 1));
    localparam logic signed [PW-1:0] SMAX  = PW'(sat_hi(OUT_W));
`ifndef BN_RELU_EN
    localparam logic signed [PW-1:0] SMIN  = PW'(sat_lo(OUT_W));
`endif

    logic adv;
    logic accept;
    logic ch_bad;
    logic signed [COEF_W-1:0] mu_c;
    logic signed [COEF_W-1:0] delta_c;
    logic signed [COEF_W-1:0] beta_c;

    logic                     v1;
    logic                     bad1;
    logic [CH_W-1:0]          ch1;
    logic signed [DW-1:0]     diff1;
    logic signed [COEF_W-1:0] delta1;
    logic signed [COEF_W-1:0] beta1;

    logic                     v2;
    logic                     bad2;
    logic [CH_W-1:0]          ch2;
    logic signed [PW-1:0]     prod2;
    logic signed [COEF_W-1:0] beta2;

    logic signed [PW-1:0]     acc_c;
    logic signed [PW-1:0]     shr_c;
    logic signed [OUT_W-1:0]  res_c;
    logic                     sat_c;
    logic                     out_sat;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;
    assign ch_bad   = {1'b0, in_ch} >= NCH_L;

    bn_coef_bank #(
        .NCH     (NCH),
        .CH_W    (CH_W),
        .COEF_W  (COEF_W),
        .FRAC_SH (FRAC_SH)
    ) u_coef_bank (
        .clk      (clk),
        .rst      (rst),
        .we       (cfg_we),
        .wr_ch    (cfg_ch),
        .sel      (cfg_sel),
        .wr_data  (cfg_data),
        .rd_ch    (in_ch),
        .rd_mu    (mu_c),
        .rd_delta (delta_c),
        .rd_beta  (beta_c)
    );

    // Whole pipe moves as one; coefficients are latched at S1 so later writes
    // never affect samples already in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            v1        <= in_valid;
            diff1     <= DW'(in_data) - DW'(mu_c);
            delta1    <= delta_c;
            beta1     <= beta_c;
            ch1       <= in_ch;
            bad1      <= ch_bad;

            v2        <= v1;
            prod2     <= PW'(diff1) * PW'(delta1);
            beta2     <= beta1;
            ch2       <= ch1;
            bad2      <= bad1;

            out_valid <= v2;
            out_data  <= res_c;
            out_ch    <= ch2;
            out_sat   <= v2 && sat_c;
        end
    end

    always_comb begin
        acc_c = prod2 + PW'(beta2) + RND;
        shr_c = acc_c >>> FRAC_SH;
        res_c = shr_c[OUT_W-1:0];
        sat_c = 1'b0;
`ifdef BN_RELU_EN
        if (shr_c[PW-1]) begin
            res_c = '0;
        end else if (shr_c > SMAX) begin
            res_c = SMAX[OUT_W-1:0];
            sat_c = 1'b1;
        end
`else
        if (shr_c > SMAX) begin
            res_c = SMAX[OUT_W-1:0];
            sat_c = 1'b1;
        end else if (shr_c < SMIN) begin
            res_c = SMIN[OUT_W-1:0];
            sat_c = 1'b1;
        end
`endif
        if (bad2) begin
            res_c = '0;
            sat_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt <= '0;
            err_ch  <= 1'b0;
        end else begin
            if (out_valid && out_ready && out_sat && (sat_cnt != '1))
                sat_cnt <= sat_cnt + CNT_W'(1);
            if (accept && ch_bad)
                err_ch <= 1'b1;
        end
    end

endmodule

// File: tb/tb_batch_norm_pipe.sv
// Bench for batch_norm_pipe: directed vector table, hand-written corner
// sequences and randomized traffic checked by an arithmetic reference model.
module tb_batch_norm_pipe;
    import cnn_bn_pkg::*;

    localparam int IN_W    = DEF_IN_W;
    localparam int COEF_W  = DEF_COEF_W;
    localparam int OUT_W   = DEF_OUT_W;
    localparam int FRAC_SH = DEF_FRAC_SH;
    localparam int NCH     = 6;
    localparam int CH_W    = 3;
    localparam int CNT_W   = 16;
    localparam longint UNITY = longint'(1) << FRAC_SH;
`ifdef BN_RELU_EN
    localparam longint NEG_SAT_EXP = 0;
    localparam longint SAT2_EXP    = 1;
`else
    localparam longint NEG_SAT_EXP = -256;
    localparam longint SAT2_EXP    = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid, in_ready, out_valid, out_ready, cfg_we, err_ch;
    logic signed [IN_W-1:0]   in_data;
    logic [CH_W-1:0]          in_ch, out_ch, cfg_ch;
    logic signed [OUT_W-1:0]  out_data;
    logic [1:0]               cfg_sel;
    logic signed [COEF_W-1:0] cfg_data;
    logic [CNT_W-1:0]         sat_cnt;

    batch_norm_pipe #(
        .IN_W(IN_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .FRAC_SH(FRAC_SH),
        .NCH(NCH), .CH_W(CH_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .sat_cnt(sat_cnt), .err_ch(err_ch)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint data;
        int     ch;
        bit     sat;
    } exp_t;

    typedef struct {
        int     ch;
        longint din;
        longint exp;
        string  nm;
    } vec_t;

    exp_t   sb[$];
    longint m_mu[NCH];
    longint m_delta[NCH];
    longint m_beta[NCH];
    longint m_sat = 0;
    bit     m_err = 0;
    int     n_out = 0;
    int     last_acc_cyc = 0;
    int     last_out_cyc = 0;
    longint last_out_data = 0;
    longint last_out_ch = 0;
    bit     held_v = 0;
    longint held_d = 0;
    longint held_c = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic longint floor_div(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    // out = clamp(floor(((din - mu) * delta + beta) / 2^F + 1/2))
    function automatic exp_t model(input longint din, input int ch);
        exp_t e;
        longint v;
        e.ch = ch;
        e.sat = 1'b0;
        e.data = 0;
        if (ch >= NCH) return e;
        v = floor_div((din - m_mu[ch]) * m_delta[ch] + m_beta[ch] + UNITY / 2, UNITY);
`ifdef BN_RELU_EN
        if (v < 0) v = 0;
`endif
        if (v > SAT_HI) begin
            e.data = SAT_HI;
            e.sat = 1'b1;
        end else if (v < SAT_LO) begin
            e.data = SAT_LO;
            e.sat = 1'b1;
        end else begin
            e.data = v;
        end
        return e;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_mu[i] = 0;
            m_delta[i] = UNITY;
            m_beta[i] = 0;
        end
    endfunction

    // Scoreboard: observes handshakes half a cycle before the edge that commits them.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            model_reset();
            m_sat = 0;
            m_err = 0;
            held_v = 0;
        end else begin
            if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
            if (held_v) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, held_d);
                check("hold_ch", out_ch, held_c);
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            held_c = out_ch;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL spurious_output: got data %0d ch %0d, expected no output", out_data, out_ch);
                end else begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_ch", out_ch, e.ch);
                    if (e.sat && m_sat < ((longint'(1) << CNT_W) - 1)) m_sat++;
                end
                n_out++;
                last_out_cyc = cyc;
                last_out_data = out_data;
                last_out_ch = out_ch;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(in_data, int'(in_ch)));
                if (in_ch >= NCH) m_err = 1;
                last_acc_cyc = cyc;
            end
            if (cfg_we && cfg_ch < NCH) begin
                case (cfg_sel)
                    CFG_MU:    m_mu[cfg_ch] = cfg_data;
                    CFG_DELTA: m_delta[cfg_ch] = cfg_data;
                    CFG_BETA:  m_beta[cfg_ch] = cfg_data;
                    default:   ;
                endcase
            end
        end
    end

    task automatic wait_out(input int n0, input string nm, input longint exp);
        int i;
        i = 0;
        while (n_out == n0 && i < 20) begin
            @(posedge clk);
            i++;
        end
        #1;
        if (n_out == n0) begin
            checks++;
            $display("FAIL %s: no output within 20 cycles, expected %0d", nm, exp);
        end else begin
            check(nm, last_out_data, exp);
            check({nm, "_latency"}, last_out_cyc - last_acc_cyc, 3);
        end
    endtask

    task automatic send_chk(input int ch, input longint din, input longint exp, input string nm);
        int n0;
        @(posedge clk); #1;
        n0 = n_out;
        in_valid = 1'b1;
        in_ch = CH_W'(ch);
        in_data = IN_W'(din);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(n0, nm, exp);
    endtask

    task automatic cfg_write(input int ch, input logic [1:0] sel, input longint val);
        @(posedge clk); #1;
        cfg_we = 1'b1;
        cfg_ch = CH_W'(ch);
        cfg_sel = sel;
        cfg_data = COEF_W'(val);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check(nm, sb.size(), 0);
    endtask

    function automatic longint srange(input longint lo, input longint hi);
        return lo + longint'($urandom_range(0, 32'(hi - lo)));
    endfunction

    function automatic longint rand_coef(input logic [1:0] sel);
        case (sel)
            CFG_MU:    return srange(-200, 200);
            CFG_DELTA: return srange(-4096, 12288);
            CFG_BETA:  return srange(-131072, 131071);
            default:   return srange(-1000, 1000);
        endcase
    endfunction

    vec_t vt[6];

    initial begin
        int n0;
        int idx;
        bit acc;
        in_valid = 1'b0; in_data = '0; in_ch = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;

        vt[0] = '{0,  100, 100,         "unity_gain"};
        vt[1] = '{0, 1000, 255,         "sat_pos"};
        vt[2] = '{0, -1000, NEG_SAT_EXP, "sat_neg"};
        vt[3] = '{2,    3, 7,           "round_pos"};
        vt[4] = '{2,   -3, 4,           "round_neg"};
        vt[5] = '{2,   13, 2,           "mu_offset"};

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        check("rst_err_ch", err_ch, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        send_chk(vt[0].ch, vt[0].din, vt[0].exp, vt[0].nm);
        check("sat_cnt_unity", sat_cnt, 0);
        for (int i = 1; i < 3; i++) send_chk(vt[i].ch, vt[i].din, vt[i].exp, vt[i].nm);
        check("sat_cnt_after_clamp", sat_cnt, SAT2_EXP);

        cfg_write(2, CFG_DELTA, 4096);
        cfg_write(2, CFG_BETA, 40960);
        for (int i = 3; i < 5; i++) send_chk(vt[i].ch, vt[i].din, vt[i].exp, vt[i].nm);
        cfg_write(2, CFG_MU, 10);
        cfg_write(2, CFG_BETA, 0);
        send_chk(vt[5].ch, vt[5].din, vt[5].exp, vt[5].nm);

        // Backpressure: stream 0..15 with a five-cycle stall in the middle.
        n0 = n_out;
        idx = 0;
        for (int c = 0; c < 100 && idx < 16; c++) begin
            in_valid = 1'b1;
            in_ch = '0;
            in_data = IN_W'(idx);
            out_ready = !(c >= 6 && c < 11);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("bp_drain");
        check("bp_count", n_out - n0, 16);

        // Same-cycle write and accept on ch1: sample sees the old mu.
        @(posedge clk); #1;
        n0 = n_out;
        in_valid = 1'b1; in_ch = 3'd1; in_data = 60;
        cfg_we = 1'b1; cfg_ch = 3'd1; cfg_sel = CFG_MU; cfg_data = 50;
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_we = 1'b0;
        wait_out(n0, "race_old_mu", 60);
        send_chk(1, 60, 10, "race_new_mu");
        cfg_write(7, CFG_MU, 77);
        cfg_write(1, 2'b11, 1000);
        send_chk(1, 60, 10, "ignored_writes");
        check("err_ch_clear", err_ch, 0);
        send_chk(7, 500, 0, "bad_ch_zero");
        check("bad_ch_tag", last_out_ch, 7);
        check("err_ch_set", err_ch, 1);

        // Reset with three samples in flight.
        cfg_write(0, CFG_MU, 5);
        n0 = n_out;
        in_valid = 1'b1; in_ch = '0;
        for (int k = 0; k < 3; k++) begin
            in_data = IN_W'(10 + k);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sat_cnt", sat_cnt, 0);
        check("midrst_err_ch", err_ch, 0);
        repeat (6) @(posedge clk);
        #1;
        check("midrst_no_emit", n_out - n0, 0);
        send_chk(0, 100, 100, "midrst_coef_default");

        // Randomized traffic against the reference model.
        for (int ch = 0; ch < NCH; ch++) begin
            cfg_write(ch, CFG_MU, rand_coef(CFG_MU));
            cfg_write(ch, CFG_DELTA, rand_coef(CFG_DELTA));
            cfg_write(ch, CFG_BETA, rand_coef(CFG_BETA));
        end
        for (int c = 0; c < 1500; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_ch = ($urandom_range(0, 15) == 0) ? CH_W'($urandom_range(6, 7)) : CH_W'($urandom_range(0, 5));
            in_data = ($urandom_range(0, 3) != 0) ? IN_W'(srange(-300, 300)) : IN_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cfg_we = ($urandom_range(0, 15) == 0);
            cfg_ch = CH_W'($urandom_range(0, 7));
            cfg_sel = 2'($urandom_range(0, 3));
            cfg_data = COEF_W'(rand_coef(cfg_sel));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        cfg_we = 1'b0;
        out_ready = 1'b1;
        drain("rand_drain");
        check("rand_sat_cnt", sat_cnt, m_sat);
        check("rand_err_ch", err_ch, m_err);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
